dma_ch_sched: RTL and testbench
===============================

DMA_CH_SCHED -- requirements
Module: dma_ch_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of DMA channels; only 4 is supported.
REQ-002 SHALL have parameter QUOTA, default 16, meaning the beat budget per grant before forced re-arbitration; legal range 1..255.
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port HRESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, 4 bits: peripheral DMA requests, level-sensitive, one per channel.
REQ-006 SHALL have port ch_en, input, 4 bits: per-channel enable from the register interface.
REQ-007 SHALL have port ch_pri, input, 8 bits: 2-bit priority per channel; [2i+1:2i] belongs to channel i; 3 is highest.
REQ-008 SHALL have port beat_done, input, 1 bit: one-cycle pulse from the channel controller per completed AHB beat of the granted channel.
REQ-009 SHALL have port blk_done, input, 1 bit: one-cycle pulse when the granted channel's block transfer completes.
REQ-010 SHALL have port grant, output, 4 bits: one-hot grant to the channel controller; all zeros when idle.
REQ-011 SHALL have port grant_id, output, 2 bits: binary index of the granted channel; holds its last value when idle.
REQ-012 SHALL have port ack, output, 4 bits: one-cycle completion acknowledge to each peripheral.
REQ-013 SHALL have port abort, output, 1 bit: one-cycle pulse when a grant is revoked because ch_en dropped.

Function
REQ-014 SHALL treat channel i as eligible when req[i] & ch_en[i].
REQ-015 SHALL implement the states IDLE, ARB, GRANT and RELEASE.
REQ-016 IDLE SHALL go to ARB when any channel is eligible; otherwise it SHALL remain in IDLE.
REQ-017 ARB SHALL pick the eligible channel with the highest ch_pri.
REQ-018 ARB SHALL break ties round-robin, searching upward from last_id+1 modulo 4.
REQ-019 ARB SHALL register the winner into grant and grant_id, clear the beat counter, and go to GRANT.
REQ-020 If nothing is eligible in ARB (request withdrawn), the block SHALL return to IDLE with no grant.
REQ-021 Latency: eligibility first seen at edge N SHALL produce grant valid after edge N+2.
REQ-022 GRANT SHALL increment an 8-bit beat counter on each beat_done; the counter SHALL saturate at QUOTA.
REQ-023 GRANT exit priority (highest first): ch_en[grant_id]==0 -> abort; then blk_done -> completion; then counter==QUOTA and another eligible channel has ch_pri >= the current channel's -> preemption. All three SHALL go to RELEASE.
REQ-024 At counter==QUOTA with no competing eligible channel, the grant SHALL be kept and the counter SHALL restart at 0.
REQ-025 A beat_done coincident with any exit condition SHALL still be counted; blk_done takes precedence over quota.
REQ-026 RELEASE SHALL last exactly one cycle with grant==0 and set last_id=grant_id.
REQ-027 RELEASE after a completion exit SHALL pulse ack[grant_id]; after an abort exit it SHALL pulse abort, not ack.
REQ-028 RELEASE SHALL go to ARB if any channel is eligible, else to IDLE.
REQ-029 grant SHALL be one-hot or zero at all times; ack SHALL be one-hot or zero.
REQ-030 Changes to ch_pri during GRANT SHALL affect only the next arbitration.
REQ-031 beat_done and blk_done outside GRANT SHALL be ignored.

Reset
REQ-032 While HRESETn is low, the block SHALL force state=IDLE, grant=0, grant_id=0, ack=0, abort=0, beat counter=0 and last_id=3, so channel 0 wins the first tie.
REQ-033 Reset asserted mid-grant SHALL drop grant immediately (asynchronously) with no ack or abort pulse.

Verification
REQ-034 req=4'b1111, ch_en=4'b1111, all priorities equal, blk_done after each grant -> grants SHALL go 0,1,2,3,0 and ack SHALL pulse on each in order.
REQ-035 req[1] rises at edge N, nothing else eligible -> grant=4'b0010 and grant_id=1 SHALL be valid after edge N+2.
REQ-036 ch_pri=8'b11_00_00_00, req=4'b1001 -> channel 3 SHALL win repeatedly; channel 0 SHALL be granted only once req[3] falls.
REQ-037 QUOTA=4, channels 0 and 2 requesting at equal priority, no blk_done -> after 4 beat_done pulses, RELEASE SHALL occur, then a grant to channel 2, with no ack.
REQ-038 ch_en[grant_id] cleared during GRANT -> one abort pulse, ack stays 0, grant=0 for one cycle, then the next channel is arbitrated.
REQ-039 HRESETn pulled low mid-grant -> grant=0 immediately; after release, channel 0 SHALL win a 4-way tie.

Source files
------------

// File: rtl/dma_ch_sched.sv
// Four-channel DMA request scheduler: priority arbitration with round-robin
// tie-break, per-grant beat quota, and completion/abort signalling.
module dma_ch_sched #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned QUOTA = 16
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [3:0] req,
  input  logic [3:0] ch_en,
  input  logic [7:0] ch_pri,
  input  logic       beat_done,
  input  logic       blk_done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic [3:0] ack,
  output logic       abort
);

  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] QUOTA_C = CNT_W'(QUOTA);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARB   = 2'd1;
  localparam logic [1:0] S_GRANT = 2'd2;
  localparam logic [1:0] S_REL   = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [3:0]       grant_nxt;
  logic [1:0]       grant_id_nxt;
  logic [3:0]       ack_nxt;
  logic             abort_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, beat_cnt;
  logic [1:0]       last_id, last_id_nxt;
  logic [1:0]       cur_pri, cur_pri_nxt;

  logic [3:0] elig;
  logic [1:0] pri_a [NCH];
  logic       win_vld;
  logic [1:0] win_id;
  logic [1:0] win_pri;
  logic [1:0] idx;
  logic       comp;

  assign elig = req & ch_en;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      pri_a[i] = ch_pri[2*i +: 2];
    end
  end

  // Highest priority wins; strict '>' keeps the first hit in round-robin order.
  always_comb begin
    win_vld = 1'b0;
    win_id  = last_id;
    win_pri = 2'd0;
    idx     = last_id;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = last_id + 2'(k);
      if (elig[idx] && (!win_vld || pri_a[idx] > win_pri)) begin
        win_vld = 1'b1;
        win_id  = idx;
        win_pri = pri_a[idx];
      end
    end
  end

  // Another eligible channel at or above the priority latched at grant time.
  always_comb begin
    comp = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (elig[i] && (2'(i) != grant_id) && (pri_a[i] >= cur_pri)) begin
        comp = 1'b1;
      end
    end
  end

  assign beat_cnt = (beat_done && (cnt != QUOTA_C)) ? cnt + CNT_W'(1) : cnt;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    ack_nxt      = 4'd0;
    abort_nxt    = 1'b0;
    cnt_nxt      = cnt;
    last_id_nxt  = last_id;
    cur_pri_nxt  = cur_pri;
    case (state)
      S_IDLE: begin
        if (|elig) begin
          state_nxt = S_ARB;
        end
      end
      S_ARB: begin
        if (win_vld) begin
          grant_nxt    = 4'b0001 << win_id;
          grant_id_nxt = win_id;
          cur_pri_nxt  = win_pri;
          cnt_nxt      = '0;
          state_nxt    = S_GRANT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        cnt_nxt = beat_cnt;
        if (!ch_en[grant_id]) begin
          abort_nxt = 1'b1;
          grant_nxt = 4'd0;
          state_nxt = S_REL;
        end else if (blk_done) begin
          ack_nxt   = grant;
          grant_nxt = 4'd0;
          state_nxt = S_REL;
        end else if (cnt == QUOTA_C) begin
          if (comp) begin
            grant_nxt = 4'd0;
            state_nxt = S_REL;
          end else begin
            cnt_nxt = CNT_W'(beat_done);
          end
        end
      end
      S_REL: begin
        last_id_nxt = grant_id;
        state_nxt   = (|elig) ? S_ARB : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      grant    <= 4'd0;
      grant_id <= 2'd0;
      ack      <= 4'd0;
      abort    <= 1'b0;
      cnt      <= '0;
      last_id  <= 2'd3;
      cur_pri  <= 2'd0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
      ack      <= ack_nxt;
      abort    <= abort_nxt;
      cnt      <= cnt_nxt;
      last_id  <= last_id_nxt;
      cur_pri  <= cur_pri_nxt;
    end
  end

endmodule

// File: tb/tb_dma_ch_sched.sv
// Scoreboard bench for dma_ch_sched: directed sequences push expected
// grant/ack/abort events; a negedge monitor pops and compares them.
module tb_dma_ch_sched;

  localparam int unsigned QUOTA = 4;
  localparam logic [1:0] K_GRANT = 2'd0;
  localparam logic [1:0] K_ACK   = 2'd1;
  localparam logic [1:0] K_ABORT = 2'd2;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] req;
  logic [3:0] ch_en;
  logic [7:0] ch_pri;
  logic       beat_done;
  logic       blk_done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic [3:0] ack;
  logic       abort;

  dma_ch_sched #(.NCH(4), .QUOTA(QUOTA)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .ch_en(ch_en), .ch_pri(ch_pri),
    .beat_done(beat_done), .blk_done(blk_done), .grant(grant),
    .grant_id(grant_id), .ack(ack), .abort(abort)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] id;
    logic [3:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  logic [3:0] prev_grant = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic exp_grant(input int id);
    ev_t e;
    e.kind = K_GRANT;
    e.id   = 2'(id);
    e.val  = 4'b0001 << e.id;
    exp_q.push_back(e);
  endtask

  task automatic exp_ack(input int id);
    ev_t e;
    e.kind = K_ACK;
    e.id   = 2'(id);
    e.val  = 4'b0001 << e.id;
    exp_q.push_back(e);
  endtask

  task automatic exp_abort();
    ev_t e;
    e.kind = K_ABORT;
    e.id   = 2'd0;
    e.val  = 4'd0;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [3:0] val, input logic [1:0] id);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d val %b, required no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_val", 32'(val), 32'(e.val));
      if (kind == K_GRANT) check("grant_id", 32'(id), 32'(e.id));
    end
  endtask

  // Monitor: a new grant, any ack pulse and any abort pulse are events.
  always @(negedge HCLK) begin
    if (grant != 4'd0 && prev_grant == 4'd0) observe(K_GRANT, grant, grant_id);
    if (ack != 4'd0) observe(K_ACK, ack, 2'd0);
    if (abort) observe(K_ABORT, 4'd0, 2'd0);
    prev_grant = grant;
  end

  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int cyc = 0;
    while (grant == 4'd0 && cyc < 20) begin
      step(1);
      cyc++;
    end
    if (grant == 4'd0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: grant still 0 after 20 cycles, required a grant", name);
    end
  endtask

  task automatic wait_release(input string name);
    int cyc = 0;
    while (grant != 4'd0 && cyc < 20) begin
      step(1);
      cyc++;
    end
    if (grant != 4'd0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: grant %b after 20 cycles, required 0", name, grant);
    end
  endtask

  task automatic pulse_blk();
    blk_done = 1'b1;
    step(1);
    blk_done = 1'b0;
  endtask

  task automatic pulse_beat();
    beat_done = 1'b1;
    step(1);
    beat_done = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; req = 4'd0; ch_en = 4'd0; ch_pri = 8'd0;
    beat_done = 1'b0; blk_done = 1'b0;
    step(2);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_abort", 32'(abort), 32'h0);
    HRESETn = 1'b1;
    step(1);

    // Four-way tie rotates 0,1,2,3,0 with an ack per completion.
    ch_en = 4'b1111;
    exp_grant(0);
    req = 4'b1111;
    wait_grant("rr_first");
    for (int k = 0; k < 4; k++) begin
      exp_ack(k);
      exp_grant((k + 1) % 4);
      pulse_blk();
      wait_grant("rr_next");
    end
    req = 4'd0;
    exp_ack(0);
    pulse_blk();
    step(3);

    // Two-edge latency from a lone request.
    req = 4'b0010;
    exp_grant(1);
    step(1);
    check("lat_n1_grant", 32'(grant), 32'h0);
    step(1);
    check("lat_n2_grant", 32'(grant), 32'h2);
    check("lat_n2_id", 32'(grant_id), 32'h1);
    req = 4'd0;
    exp_ack(1);
    pulse_blk();
    step(3);

    // Highest priority repeatedly wins over round-robin.
    ch_pri = 8'b11_00_00_00;
    req = 4'b1001;
    exp_grant(3);
    wait_grant("pri_first");
    repeat (2) begin
      exp_ack(3);
      exp_grant(3);
      pulse_blk();
      wait_grant("pri_again");
    end
    req = 4'b0001;
    exp_ack(3);
    exp_grant(0);
    pulse_blk();
    wait_grant("pri_low");
    req = 4'b1000;
    exp_ack(0);
    exp_grant(3);
    pulse_blk();
    wait_grant("pri_park3");
    req = 4'd0;
    exp_ack(3);
    pulse_blk();
    step(3);
    ch_pri = 8'd0;

    // Quota preemption between equal-priority channels 0 and 2, no ack.
    req = 4'b0101;
    exp_grant(0);
    wait_grant("quota_first");
    exp_grant(2);
    repeat (QUOTA) pulse_beat();
    wait_grant("quota_preempt");

    // Channel disable mid-grant: abort pulse, then re-arbitration.
    exp_abort();
    exp_grant(0);
    ch_en = 4'b1011;
    wait_release("abort_rel");
    check("abort_pulse", 32'(abort), 32'h1);
    check("abort_no_ack", 32'(ack), 32'h0);
    step(1);
    check("abort_one_cycle", 32'(abort), 32'h0);
    wait_grant("abort_next");

    // Quota reached with no competitor keeps the grant.
    repeat (QUOTA) pulse_beat();
    step(2);
    check("quota_keep", 32'(grant), 32'h1);

    // Asynchronous reset mid-grant, then channel 0 wins a fresh tie.
    ch_en = 4'b1111;
    req = 4'b1111;
    step(1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_grant_id", 32'(grant_id), 32'h0);
    check("arst_ack", 32'(ack), 32'h0);
    check("arst_abort", 32'(abort), 32'h0);
    step(2);
    exp_grant(0);
    HRESETn = 1'b1;
    wait_grant("post_reset_tie");
    req = 4'd0;
    exp_ack(0);
    pulse_blk();
    step(3);

    // Completion pulses outside GRANT must produce nothing.
    pulse_blk();
    pulse_beat();
    step(4);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
